encoder4_2_event: RTL and testbench

- Four-line event encoder, the inverse of the team's 2-to-4 decoder.
- Captures rising edges on four asynchronous input lines and holds them as pending events.
- Presents the highest-priority pending event as a 2-bit code (A = MSB, B = LSB) with a valid/ready handshake.
- A/B use the same code assignment the decoder consumes: line 0 = 00, line 1 = 01, line 2 = 10, line 3 = 11.

---
 rtl/encoder4_2_event.sv | 105 ++++++++++
 tb/tb_encoder4_2_event.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder4_2_event.sv
// Four-line event encoder: synchronizes asynchronous lines, latches rising edges as pending
// events and presents the highest-priority one as a 2-bit code over a valid/ready handshake.
module encoder4_2_event #(
  parameter int SYNC_STAGES = 2,
  parameter bit HIGH_FIRST  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] in_line,
  input  logic       ready,
  input  logic       clr_ovf,
  output logic       A,
  output logic       B,
  output logic       valid,
  output logic [3:0] pending,
  output logic       overflow
);

  // Handshake: a code is transferred on every rising clk edge where valid && ready.
  // valid only rises from IDLE and stays high with A/B frozen until that transfer.
  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t                          state_q, state_d;
  logic [SYNC_STAGES-1:0][3:0]     sync_q;
  logic [3:0]                      sync_out;
  logic [3:0]                      prev_q;
  logic [3:0]                      rise_q;
  logic [3:0]                      clear_vec;
  logic [3:0]                      capture;
  logic [3:0]                      pending_d;
  logic                            ovf_hit;
  logic                            overflow_d;
  logic                            load;
  logic                            accept;

  function automatic logic [1:0] pick(input logic [3:0] p);
    logic [1:0] r;
    r = 2'b00;
    if (HIGH_FIRST) begin
      for (int i = 0; i < 4; i++) if (p[i]) r = i[1:0];
    end else begin
      for (int i = 3; i >= 0; i--) if (p[i]) r = i[1:0];
    end
    return r;
  endfunction

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Edge detection is registered so the rise reaches pending one cycle after the edge flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
      rise_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_line};
      prev_q <= sync_out;
      rise_q <= sync_out & ~prev_q;
    end
  end

  assign accept    = valid & ready;
  assign clear_vec = accept ? (4'b0001 << {A, B}) : 4'b0000;
  assign capture   = enable ? rise_q : 4'b0000;
  assign pending_d = (pending & ~clear_vec) | capture;
  // A rise on a line still pending (and not being accepted now) is a lost event.
  assign ovf_hit   = |(capture & pending & ~clear_vec);
  assign overflow_d = ovf_hit ? 1'b1 : (clr_ovf ? 1'b0 : overflow);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && (pending != 4'b0000)) begin
          state_d = PRESENT;
          load    = 1'b1;
        end
      end
      PRESENT: begin
        if (ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      valid    <= 1'b0;
      A        <= 1'b0;
      B        <= 1'b0;
      pending  <= 4'b0000;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid    <= (state_d == PRESENT);
      if (load) {A, B} <= pick(pending);
      pending  <= pending_d;
      overflow <= overflow_d;
    end
  end

endmodule

// File: tb/tb_encoder4_2_event.sv
// Bench for encoder4_2_event: directed scenarios plus random traffic, scored against a
// cycle-level reference model that queues the codes the encoder is expected to present.
module tb_encoder4_2_event;

  localparam int S  = 2;
  localparam bit HF = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [3:0] in_line = 4'b0000;
  logic       A, B, valid, overflow;
  logic [3:0] pending;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];
  logic [3:0] h [0:S+1] = '{default: 4'b0000};
  logic [3:0] m_pend = 4'b0000;
  logic       m_ovf = 1'b0;
  logic       m_busy = 1'b0;
  logic [1:0] m_code = 2'b00;
  logic [3:0] m_clr, m_cap;
  logic       m_hit;
  int         acc_cnt = 0;
  logic [1:0] last_acc = 2'b00;

  always #5 clk = ~clk;

  encoder4_2_event #(.SYNC_STAGES(S), .HIGH_FIRST(HF)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_line(in_line), .ready(ready),
    .clr_ovf(clr_ovf), .A(A), .B(B), .valid(valid), .pending(pending), .overflow(overflow)
  );

  function automatic logic [1:0] prio(input logic [3:0] p);
    int v, low;
    v   = int'(p);
    low = v & (-v);
    if (HF) return 2'($clog2(v + 1) - 1);
    return 2'($clog2(low));
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_valid(input int max_cycles);
    int n;
    n = 0;
    while (!valid && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (!valid) begin
      errors++;
      $display("FAIL wait_valid actual=0 expected=1 within %0d cycles", max_cycles);
    end
  endtask

  // Reference model: a line level sampled at edge t becomes a rise usable at edge t+S+1.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int j = 0; j <= S + 1; j++) h[j] = 4'b0000;
        m_pend = 4'b0000;
        m_ovf  = 1'b0;
        m_busy = 1'b0;
        m_code = 2'b00;
        exp_q.delete();
      end else begin
        m_clr = (m_busy && ready) ? 4'(1 << m_code) : 4'b0000;
        m_cap = enable ? (h[S] & ~h[S+1]) : 4'b0000;
        m_hit = 1'b0;
        if (m_busy) begin
          if (ready) m_busy = 1'b0;
        end else if (enable && m_pend != 4'b0000) begin
          m_code = prio(m_pend);
          m_busy = 1'b1;
          exp_q.push_back(m_code);
        end
        for (int i = 0; i < 4; i++) if (m_clr[i]) m_pend[i] = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (m_cap[i]) begin
            if (m_pend[i]) m_hit = 1'b1;
            m_pend[i] = 1'b1;
          end
        end
        if (m_hit) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
        for (int j = S + 1; j > 0; j--) h[j] = h[j-1];
        h[0] = in_line;
      end
    end
  end

  // Monitor: compares registered outputs mid-cycle and retires codes on valid && ready.
  initial begin
    forever begin
      @(negedge clk);
      check("valid", 8'(valid), 8'(m_busy));
      check("pending", 8'(pending), 8'(m_pend));
      check("overflow", 8'(overflow), 8'(m_ovf));
      if (valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL code actual=%b expected=none (queue empty)", {A, B});
        end else begin
          check("code", 8'({A, B}), 8'(exp_q[0]));
          if (ready) begin
            last_acc = exp_q[0];
            acc_cnt++;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("ab_hold", 8'({A, B}), 8'(m_code));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    run(3);
    check("reset_valid", 8'(valid), 8'd0);
    check("reset_pending", 8'(pending), 8'd0);
    check("reset_ovf", 8'(overflow), 8'd0);
    check("reset_ab", 8'({A, B}), 8'd0);
    rst_n = 1'b1; enable = 1'b1; ready = 1'b1;
    run(3);

    // Line 2 pulse: latency of pending and valid from the sampling edge N.
    in_line = 4'b0100;
    run(3);
    in_line = 4'b0000;
    tick();
    check("t1_pending", 8'(pending), 8'b0100);
    check("t1_valid_early", 8'(valid), 8'd0);
    tick();
    check("t1_valid", 8'(valid), 8'd1);
    check("t1_code", 8'({A, B}), 8'b10);
    tick();
    check("t1_valid_drop", 8'(valid), 8'd0);
    check("t1_pending_clr", 8'(pending), 8'd0);
    run(3);

    // Lines 0 and 3 together: 11 first, then 00.
    ready = 1'b0;
    in_line = 4'b1001;
    run(6);
    check("t2_pending", 8'(pending), 8'b1001);
    check("t2_code", 8'({A, B}), 8'b11);
    ready = 1'b1;
    run(6);
    check("t2_drain", 8'(pending), 8'd0);
    in_line = 4'b0000;
    run(3);

    // Higher-priority arrival while 01 is presented.
    ready = 1'b0;
    in_line = 4'b0010;
    run(6);
    in_line = 4'b1010;
    run(5);
    check("t3_hold", 8'({A, B}), 8'b01);
    check("t3_pending", 8'(pending), 8'b1010);
    ready = 1'b1;
    run(8);
    in_line = 4'b0000;
    run(3);

    // Overflow, its clear, and a rise exactly in the acceptance cycle.
    ready = 1'b0;
    in_line = 4'b0010;
    run(5);
    in_line = 4'b0000;
    run(2);
    in_line = 4'b0010;
    run(5);
    check("t4_ovf", 8'(overflow), 8'd1);
    check("t4_pending", 8'(pending), 8'b0010);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t4_ovf_clr", 8'(overflow), 8'd0);
    in_line = 4'b0000;
    run(3);
    in_line = 4'b0010;
    run(3);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t4_accept_ovf", 8'(overflow), 8'd0);
    check("t4_accept_pend", 8'(pending), 8'b0010);
    ready = 1'b1;
    in_line = 4'b0000;
    run(8);

    // enable low masks capture; enable drop mid-transaction still completes.
    enable = 1'b0;
    in_line = 4'b0100;
    run(6);
    check("t5_masked_pend", 8'(pending), 8'd0);
    check("t5_masked_valid", 8'(valid), 8'd0);
    in_line = 4'b0000;
    enable = 1'b1; ready = 1'b0;
    run(3);
    in_line = 4'b0001;
    wait_valid(12);
    enable = 1'b0;
    run(2);
    ready = 1'b1;
    tick();
    check("t5_done_valid", 8'(valid), 8'd0);
    check("t5_done_pend", 8'(pending), 8'd0);
    enable = 1'b1;
    in_line = 4'b0000;
    run(4);

    // Asynchronous reset during PRESENT, release with line 1 held high.
    ready = 1'b0;
    in_line = 4'b0100;
    wait_valid(12);
    in_line = 4'b0000;
    #2;
    rst_n = 1'b0;
    in_line = 4'b0010;
    #1;
    check("t6_valid", 8'(valid), 8'd0);
    check("t6_ab", 8'({A, B}), 8'd0);
    check("t6_pending", 8'(pending), 8'd0);
    check("t6_ovf", 8'(overflow), 8'd0);
    run(3);
    base = acc_cnt;
    rst_n = 1'b1;
    ready = 1'b1;
    run(12);
    check("t6_count", 8'(acc_cnt - base), 8'd1);
    check("t6_code", 8'(last_acc), 8'b01);
    in_line = 4'b0000;
    run(3);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) in_line[i] = ~in_line[i];
      ready   = ($urandom_range(0, 2) != 0);
      enable  = ($urandom_range(0, 9) != 0);
      clr_ovf = ($urandom_range(0, 15) == 0);
      tick();
    end
    in_line = 4'b0000; enable = 1'b1; ready = 1'b1; clr_ovf = 1'b0;
    run(20);
    check("drain", 8'(exp_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
